// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and the next-state opcode encoding for
// updown_counter. The wrap/saturate choice is made at compile time with the
// UPDOWN_COUNTER_SATURATE_EN macro, consumed in updown_counter.sv.
package counter_pkg;

    // Default counter width in bits.
    localparam int DEFAULT_WIDTH = 8;

    // Next-state opcode chosen each cycle by the decode logic.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    // Tie-breaking rules, highest priority first: reset, load, simultaneous
    // add/sub edges (cancel), add edge, sub edge, hold.
    localparam bit TIE_LOAD_BEATS_EDGES = 1'b1; // edges in a load cycle are dropped
    localparam bit TIE_BOTH_EDGES_HOLD  = 1'b1; // add+sub in one cycle: no change
    localparam bit TIE_FLAG_SET_WINS    = 1'b1; // set beats clear_flags in one cycle

endpackage

// File: rtl/updown_counter_edge_detect.sv
// edge_detect: one-bit rising-edge detector. The previous-sample register
// loads the live input even while reset is high, so a level that is already
// high when reset releases is not seen as a new edge.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_q;

    // Previous-cycle sample; reset deliberately loads the current input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= i_level;
        end else begin
            r_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_q;

endmodule

// File: rtl/updown_counter.sv
// updown_counter: up/down modulo-MODULUS counter with edge-detected add/sub
// requests, synchronous load, sticky carry/borrow flags and a registered
// terminal-count output.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the range ends instead of
// wrapping; flag behaviour is the same in both builds.
//
// Handshake: there is none; add and sub are level strobes and each 0->1
// transition seen at a clock edge is one request. They must return low for at
// least one cycle between requests.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             add,
    input  logic             sub,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] value_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             terminal
);

    // Range limits held one bit wider so MODULUS == 2**WIDTH fits the compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_value;
    logic             r_carry;
    logic             r_borrow;
    logic             r_terminal;

    logic             w_add_rise;
    logic             w_sub_rise;
    op_e              w_op;
    logic [WIDTH:0]   w_value_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_next_value;
    logic             w_carry_set;
    logic             w_borrow_set;

    edge_detect u_add_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (add),
        .o_rise  (w_add_rise)
    );

    edge_detect u_sub_edge (
        .clock   (clock),
        .reset   (reset),
        .i_level (sub),
        .o_rise  (w_sub_rise)
    );

    assign w_value_ext = {1'b0, r_value};
    assign w_load_ext  = {1'b0, load_value};

    // Opcode decode: load beats edges, and simultaneous edges cancel.
    always_comb begin
        w_op = OP_HOLD;
        if (load) begin
            w_op = OP_LOAD;
        end else if (w_add_rise && w_sub_rise) begin
            w_op = OP_HOLD;
        end else if (w_add_rise) begin
            w_op = OP_INC;
        end else if (w_sub_rise) begin
            w_op = OP_DEC;
        end
    end

    // Next value and flag-set strobes for the decoded opcode.
    always_comb begin
        w_next_value = r_value;
        w_carry_set  = 1'b0;
        w_borrow_set = 1'b0;
        case (w_op)
            OP_LOAD: begin
                // Out-of-range loads clamp to the top of the range.
                w_next_value = (w_load_ext < MOD_EXT) ? load_value : MAX_VAL;
            end
            OP_INC: begin
                if (w_value_ext < MAX_EXT) begin
                    // Guarded by the compare, so the WIDTH-bit add cannot overflow.
                    w_next_value = r_value + WIDTH'(1);
                end else begin
                    w_carry_set = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    w_next_value = MAX_VAL;
`else
                    w_next_value = '0;
`endif
                end
            end
            OP_DEC: begin
                if (r_value != '0) begin
                    w_next_value = r_value - WIDTH'(1);
                end else begin
                    w_borrow_set = 1'b1;
`ifdef UPDOWN_COUNTER_SATURATE_EN
                    w_next_value = '0;
`else
                    w_next_value = MAX_VAL;
`endif
                end
            end
            default: begin
                w_next_value = r_value;
            end
        endcase
    end

    // Value, sticky flags and terminal register; a flag set beats clear_flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value    <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_terminal <= 1'b0;
        end else begin
            r_value    <= w_next_value;
            r_carry    <= w_carry_set  | (r_carry  & ~clear_flags);
            r_borrow   <= w_borrow_set | (r_borrow & ~clear_flags);
            r_terminal <= (w_next_value == MAX_VAL);
        end
    end

    assign value_out  = r_value;
    assign carry_out  = r_carry;
    assign borrow_out = r_borrow;
    assign terminal   = r_terminal;

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed bench for updown_counter. A WIDTH=8 full-range
// instance runs a table of per-cycle vectors plus long pulse sequences; a
// MODULUS=10 instance covers a partial range and load clamping. Expectations
// follow the build mode selected by UPDOWN_COUNTER_SATURATE_EN.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #10 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT 8-bit, full range ----------------
    logic       reset, add, sub, load, clear_flags;
    logic [7:0] load_value;
    logic [7:0] value_out;
    logic       carry_out, borrow_out, terminal;

    updown_counter #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .add         (add),
        .sub         (sub),
        .load        (load),
        .load_value  (load_value),
        .clear_flags (clear_flags),
        .value_out   (value_out),
        .carry_out   (carry_out),
        .borrow_out  (borrow_out),
        .terminal    (terminal)
    );

    // ---------------- DUT modulo 10 ----------------
    logic       reset10, add10, sub10, load10, clear10;
    logic [7:0] load_value10;
    logic [7:0] value10;
    logic       carry10, borrow10, terminal10;

    updown_counter #(.WIDTH(8), .MODULUS(10)) dut10 (
        .clock       (clock),
        .reset       (reset10),
        .add         (add10),
        .sub         (sub10),
        .load        (load10),
        .load_value  (load_value10),
        .clear_flags (clear10),
        .value_out   (value10),
        .carry_out   (carry10),
        .borrow_out  (borrow10),
        .terminal    (terminal10)
    );

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] ev, input logic ec,
                          input logic eb, input logic et);
        cmp({name, ".value"},    value_out,         ev);
        cmp({name, ".carry"},    {7'd0, carry_out}, {7'd0, ec});
        cmp({name, ".borrow"},   {7'd0, borrow_out},{7'd0, eb});
        cmp({name, ".terminal"}, {7'd0, terminal},  {7'd0, et});
    endtask

    task automatic check10(input string name, input logic [7:0] ev, input logic ec,
                           input logic eb, input logic et);
        cmp({name, ".value10"},    value10,           ev);
        cmp({name, ".carry10"},    {7'd0, carry10},   {7'd0, ec});
        cmp({name, ".borrow10"},   {7'd0, borrow10},  {7'd0, eb});
        cmp({name, ".terminal10"}, {7'd0, terminal10},{7'd0, et});
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs, then advance one active edge and settle before checking.
    task automatic cyc8(input logic r, input logic a, input logic s, input logic l,
                        input logic [7:0] lv, input logic c);
        reset = r; add = a; sub = s; load = l; load_value = lv; clear_flags = c;
        @(posedge clock);
        #1;
    endtask

    task automatic cyc10(input logic r, input logic a, input logic s, input logic l,
                         input logic [7:0] lv, input logic c);
        reset10 = r; add10 = a; sub10 = s; load10 = l; load_value10 = lv; clear10 = c;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_add8();
        cyc8(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        cyc8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       rst, a, s, l, clr;
        logic [7:0] lv;
        logic [7:0] ev;
        logic       ec, eb, et;
    } vec_t;

    vec_t vecs[$];

    task automatic vec(input string name, input logic r, input logic a, input logic s,
                       input logic l, input logic [7:0] lv, input logic c,
                       input logic [7:0] ev, input logic ec, input logic eb, input logic et);
        vec_t v;
        v.name = name; v.rst = r; v.a = a; v.s = s; v.l = l; v.lv = lv; v.clr = c;
        v.ev = ev; v.ec = ec; v.eb = eb; v.et = et;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; add = 1'b0; sub = 1'b0; load = 1'b0; load_value = 8'd0; clear_flags = 1'b0;
        reset10 = 1'b1; add10 = 1'b0; sub10 = 1'b0; load10 = 1'b0; load_value10 = 8'd0; clear10 = 1'b0;

        //  name        rst a  s  l  lv      clr  value                    c  b  t
        // Reset then two add pulses.
        vec("rst",      1, 0, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        vec("add1_hi",  0, 1, 0, 0, 8'd0,   0, 8'd1,                    0, 0, 0);
        vec("add1_lo",  0, 0, 0, 0, 8'd0,   0, 8'd1,                    0, 0, 0);
        vec("add2_hi",  0, 1, 0, 0, 8'd0,   0, 8'd2,                    0, 0, 0);
        vec("add2_lo",  0, 0, 0, 0, 8'd0,   0, 8'd2,                    0, 0, 0);
        // Reset then a sub from 0: borrow, wrap or hold.
        vec("rst3",     1, 0, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        vec("sub0_hi",  0, 0, 1, 0, 8'd0,   0, SAT ? 8'd0 : 8'd255,     0, 1, !SAT);
        vec("sub0_lo",  0, 0, 0, 0, 8'd0,   0, SAT ? 8'd0 : 8'd255,     0, 1, !SAT);
        // clear_flags together with an add edge: the carry set wins.
        vec("clr_add",  0, 1, 0, 0, 8'd0,   1, SAT ? 8'd1 : 8'd0,       !SAT, 0, 0);
        vec("clr_add2", 0, 0, 0, 0, 8'd0,   0, SAT ? 8'd1 : 8'd0,       !SAT, 0, 0);
        vec("clr_only", 0, 0, 0, 0, 8'd0,   1, SAT ? 8'd1 : 8'd0,       0, 0, 0);
        // Load with an add edge: edge dropped, edge register still updated.
        vec("ld_edge",  0, 1, 0, 1, 8'd200, 0, 8'd200,                  0, 0, 0);
        vec("ld_held",  0, 1, 0, 0, 8'd0,   0, 8'd200,                  0, 0, 0);
        vec("ld_rel",   0, 0, 0, 0, 8'd0,   0, 8'd200,                  0, 0, 0);
        vec("ld_max",   0, 0, 0, 1, 8'd255, 0, 8'd255,                  0, 0, 1);
        vec("dec_max",  0, 0, 1, 0, 8'd0,   0, 8'd254,                  0, 0, 0);
        vec("dec_rel",  0, 0, 0, 0, 8'd0,   0, 8'd254,                  0, 0, 0);
        // add held high across reset release does not count.
        vec("rst_hold", 1, 1, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        vec("rel_hold", 0, 1, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        vec("rel_low",  0, 0, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        // Simultaneous add and sub edges cancel.
        vec("both",     0, 1, 1, 0, 8'd0,   0, 8'd0,                    0, 0, 0);
        vec("both_lo",  0, 0, 0, 0, 8'd0,   0, 8'd0,                    0, 0, 0);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            cyc8(vecs[i].rst, vecs[i].a, vecs[i].s, vecs[i].l, vecs[i].lv, vecs[i].clr);
            check8(vecs[i].name, vecs[i].ev, vecs[i].ec, vecs[i].eb, vecs[i].et);
        end

        // ---- 256 add pulses starting from 2 ----
        cyc8(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        pulse_add8();
        pulse_add8();
        check8("from2", 8'd2, 0, 0, 0);
        for (int k = 0; k < 256; k++) pulse_add8();
        if (SAT) check8("add256", 8'd255, 1, 0, 1);
        else     check8("add256", 8'd2,   1, 0, 0);

        // ---- count to 37, sub, reset with a coincident add edge ----
        cyc8(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 37; k++) pulse_add8();
        check8("cnt37", 8'd37, 0, 0, 0);
        cyc8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        cyc8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check8("dec36", 8'd36, 0, 0, 0);
        pulse_add8();
        cyc8(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        check8("rst_edge", 8'd0, 0, 0, 0);
        cyc8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check8("rst_edge2", 8'd0, 0, 0, 0);
        pulse_add8();
        check8("after_rst", 8'd1, 0, 0, 0);

        // ---- MODULUS=10 instance ----
        cyc10(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check10("m10_rst", 8'd0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            logic [7:0] ev;
            cyc10(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            if (SAT) ev = (k > 9) ? 8'd9 : 8'(k);
            else     ev = 8'(k % 10);
            check10($sformatf("m10_add%0d", k), ev, k >= 10, 0, ev == 8'd9);
            cyc10(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        end
        cyc10(1'b0, 1'b0, 1'b0, 1'b1, 8'd12, 1'b0);
        check10("m10_ld12", 8'd9, 1, 0, 1);
        cyc10(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
        check10("m10_ld5", 8'd5, 1, 0, 0);
        cyc10(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check10("m10_ld5b", 8'd5, 1, 0, 0);
        cyc10(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1);
        check10("m10_ld0", 8'd0, 0, 0, 0);
        cyc10(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        check10("m10_dec0", SAT ? 8'd0 : 8'd9, 0, 1, !SAT);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
